// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - five-stage pipeline sequencer: register enables, bubbles, flushes
// and stall/bubble/flush event counters.
module pipe_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_resp,
  input  logic             dmem_resp,
  input  logic             mem_rd,
  input  logic             mem_wr,
  input  logic             br_taken,
  input  logic             ex_is_load,
  input  logic [2:0]       ex_dest,
  input  logic [2:0]       id_src1,
  input  logic [2:0]       id_src2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic             cnt_clr,
  output logic             imem_read,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             pc_sel_br,
  output logic             squash_if_id,
  output logic             squash_id_ex,
  output logic             squash_ex_mem,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic             i_done_q, i_done_d;
  logic             d_done_q, d_done_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic mem_acc, i_ok, d_ok, advance, luh, go, go_br, go_luh;

  assign mem_acc = mem_rd | mem_wr;
  assign i_ok    = i_done_q | imem_resp;
  assign d_ok    = !mem_acc | d_done_q | dmem_resp;
  assign advance = i_ok & d_ok;

  assign luh = ex_is_load & ((id_use1 & (id_src1 == ex_dest)) |
                             (id_use2 & (id_src2 == ex_dest)));

  // Enables are held off while reset is asserted even if responses are present.
  assign go     = advance & !reset;
  assign go_br  = go & br_taken;
  assign go_luh = go & luh & !br_taken;

  assign imem_read  = !i_done_q;
  assign dmem_read  = mem_rd & !d_done_q;
  assign dmem_write = mem_wr & !d_done_q;

  always_comb begin
    load_pc       = 1'b0;
    load_if_id    = 1'b0;
    load_id_ex    = 1'b0;
    load_ex_mem   = 1'b0;
    load_mem_wb   = 1'b0;
    pc_sel_br     = 1'b0;
    squash_if_id  = 1'b0;
    squash_id_ex  = 1'b0;
    squash_ex_mem = 1'b0;
    if (go) begin
      load_id_ex  = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
      if (go_br) begin
        load_pc       = 1'b1;
        load_if_id    = 1'b1;
        pc_sel_br     = 1'b1;
        squash_if_id  = 1'b1;
        squash_id_ex  = 1'b1;
        squash_ex_mem = 1'b1;
      end else if (go_luh) begin
        squash_id_ex = 1'b1;
      end else begin
        load_pc    = 1'b1;
        load_if_id = 1'b1;
      end
    end
  end

  // Done flags remember a response that arrived before its partner.
  always_comb begin
    i_done_d = 1'b0;
    d_done_d = 1'b0;
    if (!advance) begin
      i_done_d = i_done_q | imem_resp;
      d_done_d = d_done_q | (dmem_resp & mem_acc);
    end
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
      flush_cnt_d  = '0;
    end else begin
      if (!advance) stall_cnt_d  = stall_cnt_q + CNT_W'(1);
      if (go_luh)   bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      if (go_br)    flush_cnt_d  = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl; a 4-bit counter
// instance shares the stimulus so counter wrap is reached in few cycles.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic reset, imem_resp, dmem_resp, mem_rd, mem_wr, br_taken, ex_is_load;
  logic [2:0] ex_dest, id_src1, id_src2;
  logic id_use1, id_use2, cnt_clr;
  logic imem_read, dmem_read, dmem_write;
  logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, pc_sel_br;
  logic squash_if_id, squash_id_ex, squash_ex_mem;
  logic [15:0] stall_cnt, bubble_cnt, flush_cnt;
  logic imem_read4, dmem_read4, dmem_write4;
  logic lp4, lif4, lid4, lex4, lmw4, psb4, sq1_4, sq2_4, sq3_4;
  logic [3:0] stall4, bubble4, flush4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .imem_resp(imem_resp), .dmem_resp(dmem_resp),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .br_taken(br_taken), .ex_is_load(ex_is_load),
    .ex_dest(ex_dest), .id_src1(id_src1), .id_src2(id_src2), .id_use1(id_use1),
    .id_use2(id_use2), .cnt_clr(cnt_clr), .imem_read(imem_read), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .load_pc(load_pc), .load_if_id(load_if_id),
    .load_id_ex(load_id_ex), .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .pc_sel_br(pc_sel_br), .squash_if_id(squash_if_id), .squash_id_ex(squash_id_ex),
    .squash_ex_mem(squash_ex_mem), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
    .flush_cnt(flush_cnt)
  );

  pipe_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .imem_resp(imem_resp), .dmem_resp(dmem_resp),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .br_taken(br_taken), .ex_is_load(ex_is_load),
    .ex_dest(ex_dest), .id_src1(id_src1), .id_src2(id_src2), .id_use1(id_use1),
    .id_use2(id_use2), .cnt_clr(cnt_clr), .imem_read(imem_read4), .dmem_read(dmem_read4),
    .dmem_write(dmem_write4), .load_pc(lp4), .load_if_id(lif4), .load_id_ex(lid4),
    .load_ex_mem(lex4), .load_mem_wb(lmw4), .pc_sel_br(psb4), .squash_if_id(sq1_4),
    .squash_id_ex(sq2_4), .squash_ex_mem(sq3_4), .stall_cnt(stall4),
    .bubble_cnt(bubble4), .flush_cnt(flush4)
  );

  wire [4:0] loads  = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb};
  wire [2:0] squash = {squash_if_id, squash_id_ex, squash_ex_mem};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    reset = 1'b1; imem_resp = 0; dmem_resp = 0; mem_rd = 1; mem_wr = 0;
    br_taken = 0; ex_is_load = 0; ex_dest = 0; id_src1 = 0; id_src2 = 0;
    id_use1 = 0; id_use2 = 0; cnt_clr = 0;
    settle();
    check_eq("rst_imem_read", imem_read, 1);
    check_eq("rst_dmem_read", dmem_read, 1);
    check_eq("rst_dmem_write", dmem_write, 0);
    check_eq("rst_loads", loads, 5'b00000);
    check_eq("rst_stall_cnt", stall_cnt, 0);
    step();
    reset = 1'b0; mem_rd = 0;

    // zero-wait memories, no hazards
    imem_resp = 1; dmem_resp = 1;
    for (int i = 0; i < 10; i++) begin
      settle();
      check_eq("zw_loads", loads, 5'b11111);
      check_eq("zw_squash", squash, 3'b000);
      step();
    end
    check_eq("zw_stall_cnt", stall_cnt, 0);

    // imem response at cycle 0, dmem response at cycle 3
    mem_rd = 1; imem_resp = 1; dmem_resp = 0;
    settle();
    check_eq("w0_loads", loads, 5'b00000);
    check_eq("w0_imem_read", imem_read, 1);
    check_eq("w0_dmem_read", dmem_read, 1);
    step();
    imem_resp = 0;
    for (int c = 1; c <= 2; c++) begin
      settle();
      check_eq("w12_loads", loads, 5'b00000);
      check_eq("w12_imem_read", imem_read, 0);
      step();
    end
    dmem_resp = 1;
    settle();
    check_eq("w3_loads", loads, 5'b11111);
    check_eq("w3_imem_read", imem_read, 0);
    step();
    mem_rd = 0; dmem_resp = 0;
    settle();
    check_eq("w4_stall_cnt", stall_cnt, 3);
    check_eq("w4_imem_read", imem_read, 1);

    // load-use bubble, then same pattern without the use
    imem_resp = 1; dmem_resp = 1;
    ex_is_load = 1; ex_dest = 3; id_use1 = 1; id_src1 = 3;
    settle();
    check_eq("luh_loads", loads, 5'b00111);
    check_eq("luh_squash", squash, 3'b010);
    check_eq("luh_bubble_before", bubble_cnt, 0);
    step();
    id_use1 = 0;
    settle();
    check_eq("luh_bubble_after", bubble_cnt, 1);
    check_eq("nouse_loads", loads, 5'b11111);
    check_eq("nouse_squash", squash, 3'b000);
    step();
    check_eq("nouse_bubble", bubble_cnt, 1);

    // branch overrides load-use
    id_use1 = 1; br_taken = 1;
    settle();
    check_eq("br_loads", loads, 5'b11111);
    check_eq("br_pc_sel", pc_sel_br, 1);
    check_eq("br_squash", squash, 3'b111);
    step();
    br_taken = 0; ex_is_load = 0; id_use1 = 0;
    settle();
    check_eq("br_flush_cnt", flush_cnt, 1);
    check_eq("br_bubble_cnt", bubble_cnt, 1);
    check_eq("br_pc_sel_clear", pc_sel_br, 0);

    // reset while fetch done and data outstanding
    mem_rd = 1; imem_resp = 1; dmem_resp = 0;
    step();
    imem_resp = 0;
    settle();
    check_eq("mid_imem_read", imem_read, 0);
    check_eq("mid_stall_cnt", stall_cnt, 4);
    reset = 1;
    #1;
    check_eq("mid_rst_stall", stall_cnt, 0);
    check_eq("mid_rst_flush", flush_cnt, 0);
    check_eq("mid_rst_imem_read", imem_read, 1);
    check_eq("mid_rst_loads", loads, 5'b00000);
    step();
    reset = 0; mem_rd = 0;
    settle();
    check_eq("post_rst_imem_read", imem_read, 1);
    check_eq("post_rst_bubble", bubble_cnt, 0);

    // wrap on the narrow instance, then clear racing a stall
    repeat (15) step();
    check_eq("wrap_pre4", stall4, 4'hF);
    check_eq("wrap_pre16", stall_cnt, 15);
    step();
    check_eq("wrap_post4", stall4, 4'h0);
    check_eq("wrap_post16", stall_cnt, 16);
    cnt_clr = 1;
    step();
    cnt_clr = 0;
    settle();
    check_eq("clr_stall", stall_cnt, 0);
    check_eq("clr_stall4", stall4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
